// File: rtl/pprm_inverter_arbiter.sv
// Round-robin arbiter feeding one shared GF(2^8) inverter through a two-stage
// valid/ready pipeline (S1 = granted operand, S2 = registered inverse).

module pprm_inverter (
    input  logic [7:0] a_i,
    output logic [7:0] inv_o
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    // a^254 = (a^127)^2; a^(2^(k+1)-1) = (a^(2^k-1))^2 * a. Maps 0 to 0 for free.
    logic [7:0] t;
    always_comb begin
        t = a_i;
        for (int k = 0; k < 6; k++) begin
            t = gf_mul(gf_mul(t, t), a_i);
        end
        inv_o = gf_mul(t, t);
    end
endmodule

module pprm_inverter_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [7:0]           resp_data,
    output logic [ID_W-1:0]      resp_id,
    output logic                 busy
);
    logic            s1_valid_q, s1_valid_d;
    logic [7:0]      s1_data_q, s1_data_d;
    logic [ID_W-1:0] s1_id_q, s1_id_d;
    logic            resp_valid_q, resp_valid_d;
    logic [7:0]      resp_data_q, resp_data_d;
    logic [ID_W-1:0] resp_id_q, resp_id_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

    logic             adv1, adv2, gnt_any, xfer;
    logic [ID_W-1:0]  gnt_idx;
    logic [N_REQ-1:0] grant;
    logic [7:0]       gnt_data, inv_data;
    int               pos;

    assign adv2 = ~resp_valid_q | resp_ready;
    assign adv1 = ~s1_valid_q | adv2;

    // First valid requester at or above rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        pos     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            pos = int'(rr_ptr_q) + k;
            if (pos >= N_REQ) pos = pos - N_REQ;
            if (!gnt_any && req_valid[pos]) begin
                gnt_any = 1'b1;
                gnt_idx = ID_W'(pos);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            grant[i] = gnt_any && (gnt_idx == ID_W'(i));
        end
    end

    assign gnt_data  = req_data[8*int'(gnt_idx) +: 8];
    assign req_ready = (adv1 && !rst) ? grant : '0;
    assign xfer      = adv1 & gnt_any & ~rst;

    pprm_inverter u_inv (
        .a_i   (s1_data_q),
        .inv_o (inv_data)
    );

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_data_d    = s1_data_q;
        s1_id_d      = s1_id_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_id_d    = resp_id_q;
        rr_ptr_d     = rr_ptr_q;
        if (adv2) begin
            resp_valid_d = s1_valid_q;
            resp_data_d  = inv_data;
            resp_id_d    = s1_id_q;
        end
        if (adv1) begin
            s1_valid_d = gnt_any;
            if (gnt_any) begin
                s1_data_d = gnt_data;
                s1_id_d   = gnt_idx;
            end
        end
        if (xfer) begin
            rr_ptr_d = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_data_q    <= '0;
            s1_id_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_id_q    <= '0;
            rr_ptr_q     <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_data_q    <= s1_data_d;
            s1_id_q      <= s1_id_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_id_q    <= resp_id_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_id    = resp_id_q;
    assign busy       = s1_valid_q | resp_valid_q;
endmodule
